mem_stall_requester: RTL and testbench
======================================

Name: mem_stall_requester

Overview:
- Initiator side of the stalling single-cycle data/instruction memory interface.
- Accepts one word-access request at a time from the pipeline over a valid/ready handshake.
- Drives memory enable, write, address and write data, holding them stable until memory asserts ready.
- Returns read data or write completion with an error code; a watchdog aborts accesses that never complete.

Parameters:
TIMEOUT, 64, max consecutive ACCESS cycles with mem_ready low before abort (range 1..65535)
CNT_W, 16, width of wait counter and stall_count; must hold TIMEOUT

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  1  pipeline request present
req_ready  output  1  requester can accept (state IDLE)
req_wr  input  1  1 = write, 0 = read
req_addr  input  16  byte address, must be word aligned
req_wdata  input  32  write data
resp_valid  output  1  one-cycle pulse, access finished
resp_rdata  output  32  read data; 0 for writes and errors
resp_err  output  2  00 ok, 01 misaligned, 10 memory err, 11 timeout
mem_enable  output  1  to memory enable
mem_wr  output  1  to memory wr
mem_addr  output  16  to memory addr
mem_wdata  output  32  to memory data_in
mem_rdata  input  32  from memory data_out (combinational)
mem_ready  input  1  from memory ready
mem_err  input  1  from memory err
stall_count  output  CNT_W  total cycles spent in ACCESS with mem_ready low, saturating

Behaviour:
- Reset (async, immediate): state IDLE; req_ready=1 once state is IDLE; resp_valid=0, resp_rdata=0, resp_err=00; mem_enable=0, mem_wr=0, mem_addr=0, mem_wdata=0; wait counter=0; stall_count=0.
- All mem_* outputs are registered. They never glitch from req_* combinationally.
- States:
  - IDLE: req_ready=1. On req_valid:
    - req_addr[1:0]!=0: stay IDLE; next cycle resp_valid=1, resp_err=01, resp_rdata=0. Memory is never enabled.
    - Aligned: latch wr/addr/wdata (wdata forced 0 for reads) into mem_* registers; mem_enable<=1; go ACCESS; wait counter<=0.
  - ACCESS: req_ready=0; mem_* held constant.
    - mem_ready=1 at the edge: mem_enable<=0; resp_valid<=1; resp_rdata<=mem_rdata for reads, 0 for writes; resp_err<=10 if mem_err else 00; go IDLE. A write completes in memory on this same edge.
    - mem_ready=0: wait counter+1 and stall_count+1 (saturate at all-ones).
    - Wait counter reaching TIMEOUT-1 with mem_ready=0: mem_enable<=0; resp_valid<=1; resp_err<=11; resp_rdata<=0; go IDLE.
- Latency: aligned accept at edge k; mem_enable high during cycle k+1. If ready in cycle k+1, resp_valid is high in cycle k+2. Each ready-low cycle adds one.
- resp_valid is a single-cycle pulse and is cleared the following cycle.
- Back-to-back: resp_valid and req_ready can both be high in the same cycle, so a new request is accepted in the response cycle.
- mem_ready is ignored outside ACCESS.
- Reset mid-ACCESS: enable drops asynchronously; the pending request is discarded and no resp_valid is produced.

Decomposition:
- Shared package holds:
  - state enum: IDLE, ACCESS
  - resp_err codes: ERR_OK=2'b00, ERR_ALIGN=2'b01, ERR_MEM=2'b10, ERR_TIMEOUT=2'b11
  - MEM_ADDR_W=16 and MEM_DATA_W=32
- One natural sub-module, sat_counter (width-parameterised, increment/clear, saturating), instanced for both the wait counter and stall_count.

Test Plan:
- Read, ready immediate: mem 0x0010 preloaded 0xDEADBEEF, mem_ready=1 always; req read 0x0010 at cycle 0 -> mem_enable cycle 1, resp_valid cycle 2, rdata=0xDEADBEEF, err=00, stall_count=0.
- Write with stalls: mem_ready pattern 0,0,0,1; write 0x0020 data 0x12345678 -> mem_addr/mem_wdata stable 4 cycles, resp_valid cycle 5, err=00, stall_count=3, subsequent read returns 0x12345678.
- Misaligned: req read 0x0022 -> no mem_enable ever, resp_valid next cycle, err=01, rdata=0.
- Timeout: TIMEOUT=8, mem_ready tied 0 -> resp_valid with err=11 exactly 9 cycles after accept, mem_enable low afterward, req_ready=1.
- Back-to-back: second request presented in the resp_valid cycle -> accepted that cycle, mem_enable high the next cycle, no idle bubble.
- Reset mid-access: assert rst during ACCESS stall -> mem_enable=0 immediately, resp_valid never pulses, stall_count=0, req_ready=1 after deassert.

Source files
------------

// File: rtl/mem_stall_requester_pkg.sv
// Shared types and constants for the stalling memory requester.
package mem_stall_requester_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_MEM     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // Word accesses need the two byte-offset bits clear.
    function automatic logic is_word_aligned(input logic [MEM_ADDR_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mem_stall_requester_sat_counter.sv
// Width-parameterised saturating up-counter with synchronous clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Clear has priority; increments stop at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/mem_stall_requester.sv
// Initiator for a stalling single-cycle memory: one word access at a time,
// registered memory-side outputs, response with error code and a watchdog.
module mem_stall_requester
    import mem_stall_requester_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [MEM_ADDR_W-1:0] req_addr,
    input  logic [MEM_DATA_W-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [MEM_DATA_W-1:0] resp_rdata,
    output logic [1:0]            resp_err,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [MEM_DATA_W-1:0] mem_wdata,
    input  logic [MEM_DATA_W-1:0] mem_rdata,
    input  logic                  mem_ready,
    input  logic                  mem_err,
    output logic [CNT_W-1:0]      stall_count
);

    // Last wait-counter value before the watchdog fires; the abort happens on
    // the TIMEOUT-th consecutive ready-low ACCESS cycle.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_count;
    logic             stalled;
    logic             timeout_hit;
    logic             wait_clr;

    // Requests are only taken while idle; state is a register so this is glitch-free.
    assign req_ready   = (state == IDLE);
    assign stalled     = (state == ACCESS) && !mem_ready;
    assign timeout_hit = stalled && (wait_count == WAIT_LAST);
    assign wait_clr    = (state == IDLE);

    sat_counter #(.WIDTH(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (wait_clr),
        .inc   (stalled),
        .count (wait_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (stalled),
        .count (stall_count)
    );

    // Access FSM with all memory-side and response outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= ERR_OK;
            mem_enable <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (!is_word_aligned(req_addr)) begin
                            // Rejected locally; memory never sees the request.
                            resp_valid <= 1'b1;
                            resp_err   <= ERR_ALIGN;
                            resp_rdata <= '0;
                        end else begin
                            mem_enable <= 1'b1;
                            mem_wr     <= req_wr;
                            mem_addr   <= req_addr;
                            mem_wdata  <= req_wr ? req_wdata : '0;
                            state      <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        mem_enable <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= (!mem_wr && !mem_err) ? mem_rdata : '0;
                        resp_err   <= mem_err ? ERR_MEM : ERR_OK;
                        state      <= IDLE;
                    end else if (timeout_hit) begin
                        mem_enable <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= ERR_TIMEOUT;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    mem_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stall_requester.sv
// Self-checking bench for mem_stall_requester with a simple memory model
// and a response scoreboard.
module tb_mem_stall_requester;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready = 1'b1;
    logic        mem_err;
    logic [15:0] stall_count;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;

    exp_t        sb[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    int          exp_stall = 0;
    int          resp_count = 0;
    int unsigned ready_delay = 0;
    int unsigned stall_left = 0;
    bit          mem_err_flag = 1'b0;
    logic [31:0] mem_arr [0:255];

    mem_stall_requester #(.TIMEOUT(8), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_enable  (mem_enable),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .mem_err     (mem_err),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write on the completing edge.
    assign mem_rdata = mem_arr[mem_addr[9:2]];
    assign mem_err   = mem_err_flag;

    always @(posedge clk) begin
        if (mem_enable && mem_wr && mem_ready)
            mem_arr[mem_addr[9:2]] <= mem_wdata;
    end

    // Ready generator: ready_delay low cycles at the start of each access.
    always @(negedge clk) begin
        if (mem_enable) begin
            if (stall_left > 0) begin
                mem_ready = 1'b0;
                stall_left = stall_left - 1;
            end else begin
                mem_ready = 1'b1;
            end
        end else begin
            mem_ready = 1'b1;
            stall_left = ready_delay;
        end
    end

    always @(negedge clk) begin
        if (resp_valid) resp_count++;
    end

    task automatic drive_req(input logic wr, input logic [15:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat, output bit ok);
        lat = 1;
        ok  = 1'b0;
        while (lat < 40) begin
            if (resp_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_enable !== 1'b0 || mem_wr !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl got ready=%b rv=%b en=%b wr=%b want 1 0 0 0", req_ready, resp_valid, mem_enable, mem_wr);
        end
        tests_run++;
        if (mem_addr !== 16'h0 || mem_wdata !== 32'h0 || resp_rdata !== 32'h0 || resp_err !== 2'b00 || stall_count !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_data got addr=%h wd=%h rd=%h err=%b sc=%0d want all zero", mem_addr, mem_wdata, resp_rdata, resp_err, stall_count);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_immediate;
        int lat; bit ok; exp_t e;
        ready_delay = 0;
        @(negedge clk);
        sb.push_back('{32'hDEAD_BEEF, 2'b00});
        drive_req(1'b0, 16'h0010, 32'hFFFF_FFFF);
        tests_run++;
        if (mem_enable !== 1'b1 || mem_addr !== 16'h0010 || mem_wr !== 1'b0 || mem_wdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL rd_issue got en=%b addr=%h wr=%b wd=%h want 1 0010 0 0", mem_enable, mem_addr, mem_wr, mem_wdata);
        end
        wait_resp(lat, ok);
        tests_run++;
        if (!ok || lat != 2) begin
            tests_failed++;
            $display("FAIL rd_latency got ok=%0d lat=%0d want 1 2", ok, lat);
        end
        if (ok) begin
            e = sb.pop_front();
            tests_run++;
            if (resp_rdata !== e.rdata || resp_err !== e.err) begin
                tests_failed++;
                $display("FAIL rd_data got %h/%b want %h/%b", resp_rdata, resp_err, e.rdata, e.err);
            end
        end
        tests_run++;
        if (stall_count !== 16'(exp_stall) || mem_enable !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_after got sc=%0d en=%b want %0d 0", stall_count, mem_enable, exp_stall);
        end
        @(negedge clk);
        tests_run++;
        if (resp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_pulse got resp_valid=%b want 0", resp_valid);
        end
    endtask

    task automatic test_write_stall;
        int lat; bit ok; exp_t e; int en_cycles; int bad;
        ready_delay = 3;
        @(negedge clk);
        sb.push_back('{32'h0, 2'b00});
        drive_req(1'b1, 16'h0020, 32'h1234_5678);
        lat = 1; ok = 1'b0; en_cycles = 0; bad = 0;
        while (lat < 40) begin
            if (resp_valid) begin ok = 1'b1; break; end
            if (mem_enable) begin
                en_cycles++;
                if (mem_addr !== 16'h0020 || mem_wdata !== 32'h1234_5678 || mem_wr !== 1'b1) bad++;
            end
            @(negedge clk);
            lat++;
        end
        exp_stall += 3;
        tests_run++;
        if (!ok || lat != 5 || en_cycles != 4 || bad != 0) begin
            tests_failed++;
            $display("FAIL wr_stall got ok=%0d lat=%0d en=%0d bad=%0d want 1 5 4 0", ok, lat, en_cycles, bad);
        end
        if (ok) begin
            e = sb.pop_front();
            tests_run++;
            if (resp_rdata !== e.rdata || resp_err !== e.err) begin
                tests_failed++;
                $display("FAIL wr_resp got %h/%b want %h/%b", resp_rdata, resp_err, e.rdata, e.err);
            end
        end
        tests_run++;
        if (stall_count !== 16'(exp_stall)) begin
            tests_failed++;
            $display("FAIL wr_stall_count got %0d want %0d", stall_count, exp_stall);
        end
        ready_delay = 0;
        @(negedge clk);
        sb.push_back('{32'h1234_5678, 2'b00});
        drive_req(1'b0, 16'h0020, 32'h0);
        wait_resp(lat, ok);
        if (ok) begin
            e = sb.pop_front();
            tests_run++;
            if (resp_rdata !== e.rdata || resp_err !== e.err) begin
                tests_failed++;
                $display("FAIL wr_readback got %h/%b want %h/%b", resp_rdata, resp_err, e.rdata, e.err);
            end
        end else begin
            tests_run++; tests_failed++;
            $display("FAIL wr_readback no response got none want 1");
        end
    endtask

    task automatic test_misaligned;
        int lat; bit ok; exp_t e; int en_seen;
        @(negedge clk);
        sb.push_back('{32'h0, 2'b01});
        drive_req(1'b0, 16'h0022, 32'h0);
        en_seen = 0;
        wait_resp(lat, ok);
        tests_run++;
        if (!ok || lat != 1) begin
            tests_failed++;
            $display("FAIL align_latency got ok=%0d lat=%0d want 1 1", ok, lat);
        end
        if (ok) begin
            e = sb.pop_front();
            tests_run++;
            if (resp_rdata !== e.rdata || resp_err !== e.err) begin
                tests_failed++;
                $display("FAIL align_resp got %h/%b want %h/%b", resp_rdata, resp_err, e.rdata, e.err);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (mem_enable !== 1'b0) en_seen++;
            @(negedge clk);
        end
        tests_run++;
        if (en_seen != 0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL align_no_enable got en_cycles=%0d ready=%b want 0 1", en_seen, req_ready);
        end
    endtask

    task automatic test_mem_err;
        int lat; bit ok; exp_t e;
        ready_delay = 1;
        mem_err_flag = 1'b1;
        @(negedge clk);
        sb.push_back('{32'h0, 2'b10});
        drive_req(1'b0, 16'h0010, 32'h0);
        wait_resp(lat, ok);
        exp_stall += 1;
        tests_run++;
        if (!ok || lat != 3) begin
            tests_failed++;
            $display("FAIL memerr_latency got ok=%0d lat=%0d want 1 3", ok, lat);
        end
        if (ok) begin
            e = sb.pop_front();
            tests_run++;
            if (resp_err !== e.err || stall_count !== 16'(exp_stall)) begin
                tests_failed++;
                $display("FAIL memerr_resp got err=%b sc=%0d want %b %0d", resp_err, stall_count, e.err, exp_stall);
            end
        end
        mem_err_flag = 1'b0;
        ready_delay = 0;
    endtask

    task automatic test_back_to_back;
        int lat; bit ok; exp_t e;
        ready_delay = 0;
        @(negedge clk);
        sb.push_back('{32'hDEAD_BEEF, 2'b00});
        drive_req(1'b0, 16'h0010, 32'h0);
        wait_resp(lat, ok);
        if (ok) begin
            e = sb.pop_front();
            tests_run++;
            if (resp_rdata !== e.rdata || req_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_first got rd=%h ready=%b want %h 1", resp_rdata, req_ready, e.rdata);
            end
        end else begin
            tests_run++; tests_failed++;
            $display("FAIL b2b_first no response got none want 1");
        end
        sb.push_back('{32'h0, 2'b00});
        drive_req(1'b1, 16'h0030, 32'hA5A5_5A5A);
        tests_run++;
        if (mem_enable !== 1'b1 || mem_addr !== 16'h0030 || resp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_accept got en=%b addr=%h rv=%b want 1 0030 0", mem_enable, mem_addr, resp_valid);
        end
        wait_resp(lat, ok);
        tests_run++;
        if (!ok || lat != 2) begin
            tests_failed++;
            $display("FAIL b2b_second got ok=%0d lat=%0d want 1 2", ok, lat);
        end
        if (ok) begin
            e = sb.pop_front();
            tests_run++;
            if (resp_err !== e.err || mem_arr[12] !== 32'hA5A5_5A5A) begin
                tests_failed++;
                $display("FAIL b2b_write got err=%b mem=%h want %b a5a55a5a", resp_err, mem_arr[12], e.err);
            end
        end
    endtask

    task automatic test_timeout;
        int lat; bit ok; exp_t e;
        ready_delay = 1000;
        @(negedge clk);
        sb.push_back('{32'h0, 2'b11});
        drive_req(1'b0, 16'h0010, 32'h0);
        wait_resp(lat, ok);
        exp_stall += 8;
        tests_run++;
        if (!ok || lat != 9) begin
            tests_failed++;
            $display("FAIL timeout_latency got ok=%0d lat=%0d want 1 9", ok, lat);
        end
        if (ok) begin
            e = sb.pop_front();
            tests_run++;
            if (resp_rdata !== e.rdata || resp_err !== e.err) begin
                tests_failed++;
                $display("FAIL timeout_resp got %h/%b want %h/%b", resp_rdata, resp_err, e.rdata, e.err);
            end
        end
        tests_run++;
        if (mem_enable !== 1'b0 || req_ready !== 1'b1 || stall_count !== 16'(exp_stall)) begin
            tests_failed++;
            $display("FAIL timeout_after got en=%b ready=%b sc=%0d want 0 1 %0d", mem_enable, req_ready, stall_count, exp_stall);
        end
        ready_delay = 0;
    endtask

    task automatic test_reset_mid_access;
        int cnt0;
        ready_delay = 1000;
        @(negedge clk);
        drive_req(1'b0, 16'h0010, 32'h0);
        @(negedge clk);
        tests_run++;
        if (mem_enable !== 1'b1 || stall_count === 16'h0) begin
            tests_failed++;
            $display("FAIL rstmid_pre got en=%b sc=%0d want 1 nonzero", mem_enable, stall_count);
        end
        cnt0 = resp_count;
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (mem_enable !== 1'b0 || stall_count !== 16'h0) begin
            tests_failed++;
            $display("FAIL rstmid_async got en=%b sc=%0d want 0 0", mem_enable, stall_count);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        tests_run++;
        if (resp_count != cnt0 || req_ready !== 1'b1 || stall_count !== 16'h0 || mem_enable !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_after got resp=%0d ready=%b sc=%0d en=%b want %0d 1 0 0", resp_count, req_ready, stall_count, mem_enable, cnt0);
        end
        ready_delay = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
        mem_arr[4] = 32'hDEAD_BEEF;
        test_reset();
        test_read_immediate();
        test_write_stall();
        test_misaligned();
        test_mem_err();
        test_back_to_back();
        test_timeout();
        test_reset_mid_access();
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "bench time limit");
    end

endmodule
